memshare_rqst_sched: RTL and testbench

MEMSHARE_RQST_SCHED -- requirements
Module: memshare_rqst_sched

---
 rtl/memshare_rqst_sched.sv | 152 +++++++++++++++
 tb/tb_memshare_rqst_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memshare_rqst_sched.sv
// Shared column-bank request scheduler: splits an accepted request vector into
// batches of at most GRANT_PER_CYCLE grants. Optional macro: MEMSHARE_SCHED_STALL_CNT_EN.
module memshare_rqst_sched #(
    parameter int unsigned SHARED_BANK_NUM = 5,
    parameter int unsigned GRANT_PER_CYCLE = 2,
    parameter int unsigned BATCH_CNT_WIDTH = 3
) (
    input  logic                       sys_clk,
    input  logic                       rstn,
    input  logic [SHARED_BANK_NUM-1:0] share_rqstFlag_i,
    input  logic                       rqst_valid_i,
    output logic                       rqst_ready_o,
    output logic [SHARED_BANK_NUM-1:0] grant_o,
    output logic                       grant_valid_o,
    input  logic                       grant_ready_i,
    output logic                       endFlag_o,
    output logic [BATCH_CNT_WIDTH-1:0] batch_cnt_o
`ifdef MEMSHARE_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]                stall_cnt_o
`endif
);

    localparam int unsigned N       = SHARED_BANK_NUM;
    localparam int unsigned CW      = BATCH_CNT_WIDTH;
    localparam int unsigned STALL_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    pend_q, pend_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            gvalid_q, gvalid_d;
    logic            end_q, end_d;
    logic [CW-1:0]   bcnt_q, bcnt_d;
    logic            load_c;
    logic [N-1:0]    src_c;
    logic [N-1:0]    sel_c;

    // Lowest-indexed set bits of v, at most GRANT_PER_CYCLE of them.
    function automatic logic [N-1:0] pick_low(input logic [N-1:0] v);
        logic [N-1:0] sel;
        int unsigned  cnt;
        sel = '0;
        cnt = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (v[i] && (cnt < GRANT_PER_CYCLE)) begin
                sel[i] = 1'b1;
                cnt++;
            end
        end
        return sel;
    endfunction

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        grant_d  = grant_q;
        gvalid_d = gvalid_q;
        end_d    = end_q;
        bcnt_d   = bcnt_q;
        load_c   = 1'b0;
        src_c    = pend_q;
        sel_c    = '0;

        case (state_q)
            IDLE: begin
                if (rqst_valid_i) begin
                    load_c  = 1'b1;
                    src_c   = share_rqstFlag_i;
                    bcnt_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (grant_ready_i) begin
                    if (end_q) begin
                        state_d  = IDLE;
                        pend_d   = '0;
                        grant_d  = '0;
                        gvalid_d = 1'b0;
                        end_d    = 1'b0;
                        bcnt_d   = '0;
                    end else begin
                        load_c = 1'b1;
                        bcnt_d = bcnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Batch load: grant the low bits now, keep the rest pending.
        if (load_c) begin
            sel_c    = pick_low(src_c);
            grant_d  = sel_c;
            pend_d   = src_c & ~sel_c;
            end_d    = (pend_d == '0);
            gvalid_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            grant_q  <= '0;
            gvalid_q <= 1'b0;
            end_q    <= 1'b0;
            bcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            grant_q  <= grant_d;
            gvalid_q <= gvalid_d;
            end_q    <= end_d;
            bcnt_q   <= bcnt_d;
        end
    end

`ifdef MEMSHARE_SCHED_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    // Saturating count of ISSUE cycles held by downstream back-pressure.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == ISSUE) && !grant_ready_i && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

    assign rqst_ready_o  = (state_q == IDLE);
    assign grant_o       = grant_q;
    assign grant_valid_o = gvalid_q;
    assign endFlag_o     = end_q;
    assign batch_cnt_o   = bcnt_q;

endmodule

// File: tb/tb_memshare_rqst_sched.sv
// Directed bench for memshare_rqst_sched with default parameters (5 requestors, 2 grants per batch).
module tb_memshare_rqst_sched;

    logic       sys_clk;
    logic       rstn;
    logic [4:0] share_rqstFlag_i;
    logic       rqst_valid_i;
    logic       rqst_ready_o;
    logic [4:0] grant_o;
    logic       grant_valid_o;
    logic       grant_ready_i;
    logic       endFlag_o;
    logic [2:0] batch_cnt_o;
`ifdef MEMSHARE_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
`endif

    int vec_cnt;
    int err_cnt;

    memshare_rqst_sched dut (
        .sys_clk         (sys_clk),
        .rstn            (rstn),
        .share_rqstFlag_i(share_rqstFlag_i),
        .rqst_valid_i    (rqst_valid_i),
        .rqst_ready_o    (rqst_ready_o),
        .grant_o         (grant_o),
        .grant_valid_o   (grant_valid_o),
        .grant_ready_i   (grant_ready_i),
        .endFlag_o       (endFlag_o),
        .batch_cnt_o     (batch_cnt_o)
`ifdef MEMSHARE_SCHED_STALL_CNT_EN
        ,
        .stall_cnt_o     (stall_cnt_o)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        share_rqstFlag_i = 5'b11111;
        rqst_valid_i = 1'b1;
        grant_ready_i = 1'b1;
        #1;
        vec_cnt++;
        if ({rqst_ready_o, grant_valid_o, grant_o, endFlag_o, batch_cnt_o} !== 11'b1_0_00000_0_000) begin
            err_cnt++;
            $display("FAIL reset_state: got %b exp %b",
                     {rqst_ready_o, grant_valid_o, grant_o, endFlag_o, batch_cnt_o}, 11'b1_0_00000_0_000);
        end
        cyc();
        vec_cnt++;
        if ({rqst_ready_o, grant_valid_o} !== 2'b10) begin
            err_cnt++;
            $display("FAIL reset_held: got %b exp 10", {rqst_ready_o, grant_valid_o});
        end
        rqst_valid_i = 1'b0;
        share_rqstFlag_i = 5'b00000;
        rstn = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        share_rqstFlag_i = 5'b10100;
        rqst_valid_i = 1'b1;
        grant_ready_i = 1'b1;
        cyc();
        rqst_valid_i = 1'b0;
        vec_cnt++;
        if ({rqst_ready_o, grant_valid_o, grant_o, endFlag_o, batch_cnt_o} !== 11'b0_1_10100_1_000) begin
            err_cnt++;
            $display("FAIL single_batch: got %b exp %b",
                     {rqst_ready_o, grant_valid_o, grant_o, endFlag_o, batch_cnt_o}, 11'b0_1_10100_1_000);
        end
        cyc();
        vec_cnt++;
        if ({rqst_ready_o, grant_valid_o, grant_o, endFlag_o, batch_cnt_o} !== 11'b1_0_00000_0_000) begin
            err_cnt++;
            $display("FAIL single_idle: got %b exp %b",
                     {rqst_ready_o, grant_valid_o, grant_o, endFlag_o, batch_cnt_o}, 11'b1_0_00000_0_000);
        end
    endtask

    task automatic test_all_ones();
        logic [4:0] eg [0:2];
        eg[0] = 5'b00011;
        eg[1] = 5'b01100;
        eg[2] = 5'b10000;
        share_rqstFlag_i = 5'b11111;
        rqst_valid_i = 1'b1;
        grant_ready_i = 1'b1;
        cyc();
        rqst_valid_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            vec_cnt++;
            if ({grant_valid_o, grant_o, endFlag_o, batch_cnt_o} !== {1'b1, eg[b], (b == 2), 3'(b)}) begin
                err_cnt++;
                $display("FAIL all_ones_batch%0d: got %b exp %b", b,
                         {grant_valid_o, grant_o, endFlag_o, batch_cnt_o}, {1'b1, eg[b], (b == 2), 3'(b)});
            end
            cyc();
        end
        vec_cnt++;
        if ({rqst_ready_o, grant_valid_o} !== 2'b10) begin
            err_cnt++;
            $display("FAIL all_ones_idle: got %b exp 10", {rqst_ready_o, grant_valid_o});
        end
    endtask

    task automatic test_zero();
        share_rqstFlag_i = 5'b00000;
        rqst_valid_i = 1'b1;
        grant_ready_i = 1'b1;
        cyc();
        rqst_valid_i = 1'b0;
        vec_cnt++;
        if ({rqst_ready_o, grant_valid_o, grant_o, endFlag_o, batch_cnt_o} !== 11'b0_1_00000_1_000) begin
            err_cnt++;
            $display("FAIL zero_batch: got %b exp %b",
                     {rqst_ready_o, grant_valid_o, grant_o, endFlag_o, batch_cnt_o}, 11'b0_1_00000_1_000);
        end
        cyc();
        vec_cnt++;
        if ({rqst_ready_o, grant_valid_o} !== 2'b10) begin
            err_cnt++;
            $display("FAIL zero_idle: got %b exp 10", {rqst_ready_o, grant_valid_o});
        end
    endtask

    task automatic test_stall();
        share_rqstFlag_i = 5'b01011;
        rqst_valid_i = 1'b1;
        grant_ready_i = 1'b0;
        cyc();
        rqst_valid_i = 1'b0;
        share_rqstFlag_i = 5'b11111;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) grant_ready_i = 1'b1;
            vec_cnt++;
            if ({grant_valid_o, grant_o, endFlag_o, batch_cnt_o} !== 10'b1_00011_0_000) begin
                err_cnt++;
                $display("FAIL stall_hold%0d: got %b exp %b", c,
                         {grant_valid_o, grant_o, endFlag_o, batch_cnt_o}, 10'b1_00011_0_000);
            end
            cyc();
        end
        vec_cnt++;
        if ({grant_valid_o, grant_o, endFlag_o, batch_cnt_o} !== 10'b1_01000_1_001) begin
            err_cnt++;
            $display("FAIL stall_batch1: got %b exp %b",
                     {grant_valid_o, grant_o, endFlag_o, batch_cnt_o}, 10'b1_01000_1_001);
        end
`ifdef MEMSHARE_SCHED_STALL_CNT_EN
        vec_cnt++;
        if (stall_cnt_o !== 16'd3) begin
            err_cnt++;
            $display("FAIL stall_cnt: got %0d exp 3", stall_cnt_o);
        end
`endif
        cyc();
        vec_cnt++;
        if ({rqst_ready_o, grant_valid_o} !== 2'b10) begin
            err_cnt++;
            $display("FAIL stall_idle: got %b exp 10", {rqst_ready_o, grant_valid_o});
        end
    endtask

    task automatic test_reset_mid();
        share_rqstFlag_i = 5'b11111;
        rqst_valid_i = 1'b1;
        grant_ready_i = 1'b1;
        cyc();
        rqst_valid_i = 1'b0;
        cyc();
        vec_cnt++;
        if ({grant_valid_o, grant_o, batch_cnt_o} !== 9'b1_01100_001) begin
            err_cnt++;
            $display("FAIL rstmid_batch1: got %b exp %b", {grant_valid_o, grant_o, batch_cnt_o}, 9'b1_01100_001);
        end
        #2;
        rstn = 1'b0;
        #1;
        vec_cnt++;
        if ({rqst_ready_o, grant_valid_o, grant_o, endFlag_o, batch_cnt_o} !== 11'b1_0_00000_0_000) begin
            err_cnt++;
            $display("FAIL rstmid_async: got %b exp %b",
                     {rqst_ready_o, grant_valid_o, grant_o, endFlag_o, batch_cnt_o}, 11'b1_0_00000_0_000);
        end
        cyc();
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            vec_cnt++;
            if ({rqst_ready_o, grant_valid_o, grant_o} !== 7'b1_0_00000) begin
                err_cnt++;
                $display("FAIL rstmid_nogrant%0d: got %b exp %b", c,
                         {rqst_ready_o, grant_valid_o, grant_o}, 7'b1_0_00000);
            end
        end
`ifdef MEMSHARE_SCHED_STALL_CNT_EN
        vec_cnt++;
        if (stall_cnt_o !== 16'd0) begin
            err_cnt++;
            $display("FAIL rstmid_stall_cnt: got %0d exp 0", stall_cnt_o);
        end
`endif
    endtask

    // Valid held high; flags hold junk outside the accept cycle to catch late sampling.
    task automatic test_back_to_back();
        logic [4:0] vecs [0:4];
        int         exp_nb [0:4];
        logic [4:0] acc;
        int         nb;
        logic       done;
        vecs[0] = 5'b10100; exp_nb[0] = 1;
        vecs[1] = 5'b01011; exp_nb[1] = 2;
        vecs[2] = 5'b11111; exp_nb[2] = 3;
        vecs[3] = 5'b00000; exp_nb[3] = 1;
        vecs[4] = 5'b11010; exp_nb[4] = 2;
        grant_ready_i = 1'b1;
        rqst_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            vec_cnt++;
            if (rqst_ready_o !== 1'b1) begin
                err_cnt++;
                $display("FAIL b2b_accept_ready%0d: got %b exp 1", k, rqst_ready_o);
            end
            share_rqstFlag_i = vecs[k];
            cyc();
            acc = '0;
            nb = 0;
            done = 1'b0;
            while (!done && nb < 8) begin
                share_rqstFlag_i = ~vecs[k];
                vec_cnt++;
                if ({rqst_ready_o, grant_valid_o} !== 2'b01) begin
                    err_cnt++;
                    $display("FAIL b2b_issue%0d_%0d: got %b exp 01", k, nb, {rqst_ready_o, grant_valid_o});
                end
                acc = acc | grant_o;
                done = endFlag_o;
                nb++;
                cyc();
            end
            vec_cnt++;
            if ({acc, nb[3:0]} !== {vecs[k], exp_nb[k][3:0]}) begin
                err_cnt++;
                $display("FAIL b2b_scoreboard%0d: got grants %b batches %0d exp %b batches %0d",
                         k, acc, nb, vecs[k], exp_nb[k]);
            end
        end
        rqst_valid_i = 1'b0;
        cyc();
        vec_cnt++;
        if ({rqst_ready_o, grant_valid_o} !== 2'b10) begin
            err_cnt++;
            $display("FAIL b2b_final_idle: got %b exp 10", {rqst_ready_o, grant_valid_o});
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_single();
        test_all_ones();
        test_zero();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
